// File: rtl/tetris_pkg.sv
// Shared definitions for the game input path: button indices and the
// per-channel auto-repeat state encoding.
package tetris_pkg;

    localparam int BTN_L   = 0;
    localparam int BTN_T   = 1;
    localparam int BTN_R   = 2;
    localparam int BTN_D   = 3;
    localparam int NUM_BTN = 4;

    // HOLD is the held-wait state of channels that fire only once per press.
    typedef enum logic [1:0] {
        CH_IDLE   = 2'd0,
        CH_HOLD   = 2'd1,
        CH_DELAY  = 2'd2,
        CH_REPEAT = 2'd3
    } ch_state_t;

    function automatic int unsigned max_uint(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_channel.sv
// One button: synchroniser, debouncer and delayed-auto-repeat pulse generator.
// Pulses are registered and are high for exactly one clk cycle.
module button_channel
    import tetris_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 251750,
    parameter int unsigned REPEAT_DELAY    = 4028000,
    parameter int unsigned REPEAT_RATE     = 1259000,
    parameter bit          REPEAT_EN       = 1'b1,
    parameter bit          ACTIVE_LOW      = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic butt_raw,
    output logic press_pulse,
    output logic held
);

    localparam int DCNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RCNT_W = $clog2(max_uint(REPEAT_DELAY, REPEAT_RATE) + 1);

    localparam logic [DCNT_W-1:0] DCNT_LAST   = DCNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RCNT_W-1:0] DELAY_LAST  = RCNT_W'(REPEAT_DELAY - 1);
    localparam logic [RCNT_W-1:0] RATE_LAST   = RCNT_W'(REPEAT_RATE - 1);
    // First stage still carries raw polarity, so it resets to the raw "released" level.
    localparam logic [SYNC_STAGES-1:0] SYNC_RESET = SYNC_STAGES'(ACTIVE_LOW);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic [SYNC_STAGES-1:0] sync_next;
    logic                   s;

    logic [DCNT_W-1:0] dcnt_reg;
    logic              held_reg;
    logic              debounce_done;
    logic              rise;
    logic              fall;

    ch_state_t         state_reg;
    ch_state_t         state_next;
    logic [RCNT_W-1:0] rcnt_reg;
    logic [RCNT_W-1:0] rcnt_next;
    logic              pulse_reg;
    logic              pulse_next;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                assign sync_next[gi] = butt_raw;
            end else if (gi == 1) begin : g_invert
                assign sync_next[gi] = sync_reg[0] ^ ACTIVE_LOW;
            end else begin : g_chain
                assign sync_next[gi] = sync_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_reg <= SYNC_RESET;
        end else begin
            sync_reg <= sync_next;
        end
    end

    assign s = sync_reg[SYNC_STAGES-1];

    // Any cycle where s agrees with held restarts the stability count.
    assign debounce_done = (s != held_reg) && (dcnt_reg == DCNT_LAST);
    assign rise          = debounce_done && s;
    assign fall          = debounce_done && !s;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dcnt_reg <= '0;
            held_reg <= 1'b0;
        end else if (s == held_reg) begin
            dcnt_reg <= '0;
        end else if (debounce_done) begin
            held_reg <= s;
            dcnt_reg <= '0;
        end else begin
            dcnt_reg <= dcnt_reg + DCNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= CH_IDLE;
            rcnt_reg  <= '0;
            pulse_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            rcnt_reg  <= rcnt_next;
            pulse_reg <= pulse_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        rcnt_next  = rcnt_reg;
        if (fall) begin
            state_next = CH_IDLE;
            rcnt_next  = '0;
        end else begin
            case (state_reg)
                CH_IDLE: begin
                    if (rise) begin
                        state_next = REPEAT_EN ? CH_DELAY : CH_HOLD;
                        rcnt_next  = '0;
                    end
                end
                CH_HOLD: begin
                    state_next = CH_HOLD;
                end
                CH_DELAY: begin
                    if (rcnt_reg == DELAY_LAST) begin
                        state_next = CH_REPEAT;
                        rcnt_next  = '0;
                    end else begin
                        rcnt_next = rcnt_reg + RCNT_W'(1);
                    end
                end
                CH_REPEAT: begin
                    if (rcnt_reg == RATE_LAST) begin
                        rcnt_next = '0;
                    end else begin
                        rcnt_next = rcnt_reg + RCNT_W'(1);
                    end
                end
                default: begin
                    state_next = CH_IDLE;
                    rcnt_next  = '0;
                end
            endcase
        end
    end

    // A release on the same edge as a due repeat suppresses the pulse.
    always_comb begin
        pulse_next = 1'b0;
        if (!fall) begin
            case (state_reg)
                CH_IDLE:   pulse_next = rise;
                CH_DELAY:  pulse_next = (rcnt_reg == DELAY_LAST);
                CH_REPEAT: pulse_next = (rcnt_reg == RATE_LAST);
                default:   pulse_next = 1'b0;
            endcase
        end
    end

    assign press_pulse = pulse_reg;
    assign held        = held_reg;

endmodule

// File: rtl/button_conditioner.sv
// Conditions the four raw board buttons {D,R,T,L} into debounced levels and
// press/auto-repeat pulses for the game logic; one independent channel per button.
module button_conditioner
    import tetris_pkg::*;
#(
    parameter int unsigned        SYNC_STAGES     = 2,
    parameter int unsigned        DEBOUNCE_CYCLES = 251750,
    parameter int unsigned        REPEAT_DELAY    = 4028000,
    parameter int unsigned        REPEAT_RATE     = 1259000,
    parameter logic [NUM_BTN-1:0] REPEAT_MASK     = 4'b1101,
    parameter bit                 ACTIVE_LOW      = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] butt_raw,
    output logic [NUM_BTN-1:0] press_pulse,
    output logic [NUM_BTN-1:0] held
);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BTN; gi++) begin : g_chan
            button_channel #(
                .SYNC_STAGES     (SYNC_STAGES),
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .REPEAT_DELAY    (REPEAT_DELAY),
                .REPEAT_RATE     (REPEAT_RATE),
                .REPEAT_EN       (REPEAT_MASK[gi]),
                .ACTIVE_LOW      (ACTIVE_LOW)
            ) u_chan (
                .clk         (clk),
                .reset       (reset),
                .butt_raw    (butt_raw[gi]),
                .press_pulse (press_pulse[gi]),
                .held        (held[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench: a timing reference model predicts pulses and held levels
// for an active-high and an active-low instance driven with directed and random buttons.
module tb_button_conditioner;

    localparam int          SYNC = 2;
    localparam int          DEB  = 4;
    localparam int          RD   = 10;
    localparam int          RR   = 3;
    localparam logic [3:0]  MASK = 4'b1101;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] raw_a, raw_b;
    logic [3:0] pulse_a, held_a, pulse_b, held_b;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    button_conditioner #(
        .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .REPEAT_DELAY(RD),
        .REPEAT_RATE(RR), .REPEAT_MASK(MASK), .ACTIVE_LOW(1'b0)
    ) u_dut_a (
        .clk(clk), .reset(reset), .butt_raw(raw_a),
        .press_pulse(pulse_a), .held(held_a)
    );

    button_conditioner #(
        .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .REPEAT_DELAY(RD),
        .REPEAT_RATE(RR), .REPEAT_MASK(MASK), .ACTIVE_LOW(1'b1)
    ) u_dut_b (
        .clk(clk), .reset(reset), .butt_raw(raw_b),
        .press_pulse(pulse_b), .held(held_b)
    );

    typedef struct {
        int         cyc;
        logic [3:0] pulse;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    // Reference model: delay line for the synchroniser, sliding window of the
    // last DEB samples for debounce, and press timestamps for repeat arithmetic.
    logic [3:0] dl     [2][SYNC];
    logic [3:0] win    [2][DEB];
    logic [3:0] held_m [2];
    int         press_e[2][4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < SYNC; k++) dl[d][k] = 4'h0;
            for (int k = 0; k < DEB; k++) win[d][k] = 4'h0;
            held_m[d] = 4'h0;
            for (int b = 0; b < 4; b++) press_e[d][b] = -1;
        end
    endtask

    always @(posedge clk) begin
        logic [3:0] corr, s_pre, pv;
        bit         allmis;
        int         dt;
        exp_t       e;
        cyc++;
        if (reset) begin
            model_reset();
        end else begin
            for (int d = 0; d < 2; d++) begin
                corr  = (d == 0) ? raw_a : ~raw_b;
                s_pre = dl[d][SYNC-1];
                for (int k = SYNC-1; k > 0; k--) dl[d][k] = dl[d][k-1];
                dl[d][0] = corr;
                for (int k = DEB-1; k > 0; k--) win[d][k] = win[d][k-1];
                win[d][0] = s_pre;
                pv = 4'h0;
                for (int b = 0; b < 4; b++) begin
                    allmis = 1'b1;
                    for (int k = 0; k < DEB; k++)
                        if (win[d][k][b] == held_m[d][b]) allmis = 1'b0;
                    if (allmis) begin
                        held_m[d][b] = ~held_m[d][b];
                        if (held_m[d][b]) begin
                            pv[b] = 1'b1;
                            press_e[d][b] = cyc;
                        end else begin
                            press_e[d][b] = -1;
                        end
                    end else if (held_m[d][b] && MASK[b] && press_e[d][b] >= 0) begin
                        dt = cyc - press_e[d][b];
                        if (dt == RD || (dt > RD && ((dt - RD) % RR) == 0)) pv[b] = 1'b1;
                    end
                end
                if (pv != 4'h0) begin
                    e.cyc   = cyc;
                    e.pulse = pv;
                    if (d == 0) q0.push_back(e);
                    else        q1.push_back(e);
                end
            end
        end
    end

    // Monitor: pops an expectation whenever one is due or the DUT pulses.
    always @(posedge clk) begin
        logic [3:0] act_p, act_h, exp_p;
        bit         have;
        exp_t       e;
        #1;
        for (int d = 0; d < 2; d++) begin
            act_p = (d == 0) ? pulse_a : pulse_b;
            act_h = (d == 0) ? held_a  : held_b;
            if (d == 0) have = (q0.size() > 0) && (q0[0].cyc == cyc);
            else        have = (q1.size() > 0) && (q1[0].cyc == cyc);
            exp_p = 4'h0;
            if (have) begin
                if (d == 0) e = q0.pop_front();
                else        e = q1.pop_front();
                exp_p = e.pulse;
            end
            if (have || act_p != 4'h0) begin
                $display("[TB] dut%0d cycle %0d press_pulse=%b expected=%b", d, cyc, act_p, exp_p);
                chk($sformatf("press_pulse_dut%0d", d), 32'(act_p), 32'(exp_p));
            end
            chk($sformatf("held_dut%0d", d), 32'(act_h), 32'(held_m[d]));
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #1;
        chk("reset_pulse_a", 32'(pulse_a), 32'h0);
        chk("reset_held_a",  32'(held_a),  32'h0);
        chk("reset_pulse_b", 32'(pulse_b), 32'h0);
        chk("reset_held_b",  32'(held_b),  32'h0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int span;
        reset = 1'b1;
        raw_a = 4'h0;
        raw_b = 4'hF;
        step(3);
        chk("init_pulse_a", 32'(pulse_a), 32'h0);
        chk("init_held_a",  32'(held_a),  32'h0);
        chk("init_pulse_b", 32'(pulse_b), 32'h0);
        chk("init_held_b",  32'(held_b),  32'h0);
        reset = 1'b0;
        step(5);

        // Clean L press with auto-repeat
        raw_a = 4'b0001; step(40);
        raw_a = 4'b0000; step(20);

        // Bouncing T: single pulse, never repeats
        raw_a[1] = 1'b1; step(2);
        raw_a[1] = 1'b0; step(2);
        raw_a[1] = 1'b1; step(40);
        raw_a[1] = 1'b0; step(20);

        // L released near a due repeat, then re-pressed
        raw_a = 4'b0001; step(15);
        raw_a = 4'b0000; step(3);
        raw_a = 4'b0001; step(20);
        raw_a = 4'b0000; step(20);

        // L and R together
        raw_a = 4'b0101; step(30);
        raw_a = 4'b0000; step(20);

        // Reset while D is repeating
        raw_a = 4'b1000; step(25);
        pulse_reset();
        step(30);
        raw_a = 4'b0000; step(20);

        // Active-low instance: drop L
        raw_b = 4'hE; step(30);
        raw_b = 4'hF; step(20);

        // Random buttons with varying bounce intensity and occasional resets
        for (int blk = 0; blk < 15; blk++) begin
            span = (blk % 3 == 0) ? 3 : ((blk % 3 == 1) ? 15 : 50);
            for (int c = 0; c < 200; c++) begin
                for (int b = 0; b < 4; b++) begin
                    if ($urandom_range(0, span - 1) == 0) raw_a[b] = ~raw_a[b];
                    if ($urandom_range(0, span - 1) == 0) raw_b[b] = ~raw_b[b];
                end
                if ($urandom_range(0, 599) == 0) pulse_reset();
                else step(1);
            end
        end

        raw_a = 4'h0;
        raw_b = 4'hF;
        step(40);
        chk("scoreboard_empty_a", 32'(q0.size()), 32'h0);
        chk("scoreboard_empty_b", 32'(q1.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
